// File: rtl/stream_demux_n.sv
// ---------------------------------------------------------------------------
// stream_demux_n
//   Registered, flow-controlled 1-to-NUM_CH stream demultiplexer. A single
//   holding register carries one beat toward the channel named by in_sel.
//   Out-of-range selects are dropped and recorded in a sticky error flag and
//   a saturating drop counter.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : producer beat valid
//   in_ready   : block accepts a beat this cycle (combinational from out_ready)
//   in_data    : producer payload [DATA_W]
//   in_sel     : destination channel index [SEL_W]
//   out_valid  : per-channel valid [NUM_CH], at most one bit set
//   out_ready  : per-channel consumer ready [NUM_CH]
//   out_data   : payload shared by all channels [DATA_W]
//   clr_err    : synchronous clear of err_sel and drop_count
//   err_sel    : sticky flag, an out-of-range select was dropped
//   drop_count : saturating count of dropped beats [16]
// ---------------------------------------------------------------------------
module stream_demux_n #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              clr_err,
  output logic              err_sel,
  output logic [15:0]       drop_count
);

  generate
    if (DATA_W < 1) begin : g_bad_data_w
      $error("stream_demux_n: DATA_W must be >= 1");
    end
    if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
      $error("stream_demux_n: NUM_CH must be in 2..16");
    end
    if ((2 ** SEL_W) < NUM_CH) begin : g_bad_sel_w
      $error("stream_demux_n: SEL_W too narrow for NUM_CH");
    end
  endgenerate

  // One extra bit so NUM_CH == 2**SEL_W is representable in the compare.
  localparam logic [SEL_W:0] LP_NUM_CH = (SEL_W + 1)'(NUM_CH);

  logic              r_hold_valid;
  logic [SEL_W-1:0]  r_hold_ch;
  logic [DATA_W-1:0] r_hold_data;
  logic              r_err_sel;
  logic [15:0]       r_drop_count;

  logic              w_sel_ready;
  logic              w_drain;
  logic              w_accept;
  logic              w_in_range;
  logic              w_load;
  logic              w_drop;

  // Ready of the held destination only; other channels' ready is ignored.
  always_comb begin
    w_sel_ready = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (r_hold_ch == SEL_W'(i)) begin
        w_sel_ready = out_ready[i];
      end
    end
  end

  always_comb begin
    in_ready   = !r_hold_valid || w_sel_ready;
    w_drain    = r_hold_valid && w_sel_ready;
    w_accept   = in_valid && in_ready;
    w_in_range = ({1'b0, in_sel} < LP_NUM_CH);
    w_load     = w_accept && w_in_range;
    w_drop     = w_accept && !w_in_range;
  end

  // Holding register: a load replaces a draining beat on the same edge; a
  // dropped beat never loads, so the held beat only clears if it drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_ch    <= '0;
      r_hold_data  <= '0;
    end else if (w_load) begin
      r_hold_valid <= 1'b1;
      r_hold_ch    <= in_sel;
      r_hold_data  <= in_data;
    end else if (w_drain) begin
      r_hold_valid <= 1'b0;
    end
  end

  // A drop in the same cycle as clr_err wins: flag set, count restarts at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sel    <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_err_sel <= 1'b1;
      if (clr_err) begin
        r_drop_count <= 16'd1;
      end else if (r_drop_count != '1) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end else if (clr_err) begin
      r_err_sel    <= 1'b0;
      r_drop_count <= '0;
    end
  end

  always_comb begin
    out_valid = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      out_valid[i] = r_hold_valid && (r_hold_ch == SEL_W'(i));
    end
  end

  assign out_data   = r_hold_data;
  assign err_sel    = r_err_sel;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_stream_demux_n.sv
module tb_stream_demux_n;

  logic clk;
  logic rst_n;

  // Instance A: NUM_CH=8, scoreboarded
  logic       a_in_valid;
  logic       a_in_ready;
  logic [7:0] a_in_data;
  logic [2:0] a_in_sel;
  logic [7:0] a_out_valid;
  logic [7:0] a_out_ready;
  logic [7:0] a_out_data;
  logic       a_clr;
  logic       a_err;
  logic [15:0] a_cnt;

  // Instance B: NUM_CH=6, out-of-range selects exist
  logic       b_in_valid;
  logic       b_in_ready;
  logic [7:0] b_in_data;
  logic [2:0] b_in_sel;
  logic [5:0] b_out_valid;
  logic [5:0] b_out_ready;
  logic [7:0] b_out_data;
  logic       b_clr;
  logic       b_err;
  logic [15:0] b_cnt;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [2:0] ch;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  stream_demux_n #(.DATA_W(8), .NUM_CH(8), .SEL_W(3)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_sel(a_in_sel),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .clr_err(a_clr), .err_sel(a_err), .drop_count(a_cnt)
  );

  stream_demux_n #(.DATA_W(8), .NUM_CH(6), .SEL_W(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_sel(b_in_sel),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .clr_err(b_clr), .err_sel(b_err), .drop_count(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expected beat on each output handshake of instance A.
  always @(negedge clk) begin
    if (rst_n && ((a_out_valid & a_out_ready) != 8'h00)) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 32'(a_out_valid), 32'h0);
      end else begin
        exp_t e;
        logic [7:0] onehot;
        e = sb.pop_front();
        onehot = 8'h01 << e.ch;
        chk("mon_valid", 32'(a_out_valid), 32'(onehot));
        chk("mon_data", 32'(a_out_data), 32'(e.data));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_sel = '0; a_out_ready = '0; a_clr = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_sel = '0; b_out_ready = '1; b_clr = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(a_out_valid), 32'h0);
    chk("rst_out_data", 32'(a_out_data), 32'h0);
    chk("rst_err", 32'(a_err), 32'h0);
    chk("rst_cnt", 32'(a_cnt), 32'h0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(a_in_ready), 32'h1);
    tick();

    // Full-throughput sweep across all channels
    a_out_ready = '1;
    for (int sel = 0; sel < 8; sel++) begin
      a_in_valid = 1'b1;
      a_in_sel   = 3'(sel);
      a_in_data  = 8'(8'hA0 + sel);
      @(negedge clk);
      chk("sweep_in_ready", 32'(a_in_ready), 32'h1);
      v = (sel == 0) ? 8'h00 : (8'h01 << (sel - 1));
      chk("sweep_out_valid", 32'(a_out_valid), 32'(v));
      sb.push_back('{ch: 3'(sel), data: 8'(8'hA0 + sel)});
      tick();
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("sweep_last_valid", 32'(a_out_valid), 32'h80);
    chk("sweep_last_data", 32'(a_out_data), 32'hA7);
    tick();

    // Stall on ch3 with unrelated ready bits toggling
    a_out_ready = 8'hF7;
    a_in_valid = 1'b1; a_in_sel = 3'd3; a_in_data = 8'h55;
    @(negedge clk);
    chk("stall_first_ready", 32'(a_in_ready), 32'h1);
    sb.push_back('{ch: 3'd3, data: 8'h55});
    tick();
    a_in_sel = 3'd5; a_in_data = 8'h66;
    for (int k = 0; k < 5; k++) begin
      a_out_ready = (k % 2 == 0) ? 8'hF7 : 8'h00;
      @(negedge clk);
      chk("stall_in_ready", 32'(a_in_ready), 32'h0);
      chk("stall_out_valid", 32'(a_out_valid), 32'h08);
      chk("stall_out_data", 32'(a_out_data), 32'h55);
      tick();
    end
    a_out_ready = '1;
    @(negedge clk);
    chk("release_in_ready", 32'(a_in_ready), 32'h1);
    sb.push_back('{ch: 3'd5, data: 8'h66});
    tick();
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("release_next_valid", 32'(a_out_valid), 32'h20);
    chk("release_next_data", 32'(a_out_data), 32'h66);
    tick();

    // Instance B: legal beat, then drops
    b_in_valid = 1'b1; b_in_sel = 3'd5; b_in_data = 8'h3C;
    @(negedge clk);
    chk("b_legal_ready", 32'(b_in_ready), 32'h1);
    tick();
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("b_legal_valid", 32'(b_out_valid), 32'h20);
    chk("b_legal_data", 32'(b_out_data), 32'h3C);
    tick();
    b_in_valid = 1'b1; b_in_sel = 3'd6; b_in_data = 8'hE6;
    @(negedge clk);
    chk("b_drop6_ready", 32'(b_in_ready), 32'h1);
    tick();
    b_in_sel = 3'd7; b_in_data = 8'hE7;
    @(negedge clk);
    chk("b_drop6_valid", 32'(b_out_valid), 32'h0);
    chk("b_drop6_err", 32'(b_err), 32'h1);
    chk("b_drop6_cnt", 32'(b_cnt), 32'h1);
    chk("b_data_kept", 32'(b_out_data), 32'h3C);
    tick();
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("b_drop7_valid", 32'(b_out_valid), 32'h0);
    chk("b_drop7_err", 32'(b_err), 32'h1);
    chk("b_drop7_cnt", 32'(b_cnt), 32'h2);
    tick();
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    @(negedge clk);
    chk("b_clr_err", 32'(b_err), 32'h0);
    chk("b_clr_cnt", 32'(b_cnt), 32'h0);
    tick();
    b_clr = 1'b1; b_in_valid = 1'b1; b_in_sel = 3'd6;
    tick();
    b_clr = 1'b0; b_in_valid = 1'b0;
    @(negedge clk);
    chk("b_clr_drop_err", 32'(b_err), 32'h1);
    chk("b_clr_drop_cnt", 32'(b_cnt), 32'h1);
    tick();

    // Drop in the same cycle the held beat drains: hold must empty
    b_out_ready = 6'b111011;
    b_in_valid = 1'b1; b_in_sel = 3'd2; b_in_data = 8'h2A;
    @(negedge clk);
    chk("b_hold_ready", 32'(b_in_ready), 32'h1);
    tick();
    b_in_sel = 3'd7;
    b_out_ready = '1;
    @(negedge clk);
    chk("b_held_valid", 32'(b_out_valid), 32'h04);
    chk("b_drain_ready", 32'(b_in_ready), 32'h1);
    tick();
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("b_drain_drop_valid", 32'(b_out_valid), 32'h0);
    chk("b_drain_drop_cnt", 32'(b_cnt), 32'h2);
    tick();

    // Saturation of drop_count
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    b_in_valid = 1'b1; b_in_sel = 3'd7;
    for (int i = 0; i < 65534; i++) begin
      tick();
    end
    @(negedge clk);
    chk("sat_fffe", 32'(b_cnt), 32'hFFFE);
    tick();
    @(negedge clk);
    chk("sat_ffff", 32'(b_cnt), 32'hFFFF);
    tick();
    @(negedge clk);
    chk("sat_hold", 32'(b_cnt), 32'hFFFF);
    b_in_valid = 1'b0;
    tick();

    // Asynchronous reset with a held beat
    a_out_ready = 8'hFD;
    a_in_valid = 1'b1; a_in_sel = 3'd1; a_in_data = 8'h77;
    @(negedge clk);
    chk("mr_ready", 32'(a_in_ready), 32'h1);
    sb.push_back('{ch: 3'd1, data: 8'h77});
    tick();
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("mr_held_valid", 32'(a_out_valid), 32'h02);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mr_out_valid", 32'(a_out_valid), 32'h0);
    chk("mr_out_data", 32'(a_out_data), 32'h0);
    chk("mr_b_cnt", 32'(b_cnt), 32'h0);
    #3;
    rst_n = 1'b1;
    a_out_ready = '1;
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mr_after_ready", 32'(a_in_ready), 32'h1);
      chk("mr_after_valid", 32'(a_out_valid), 32'h0);
      tick();
    end
    a_in_valid = 1'b1; a_in_sel = 3'd6; a_in_data = 8'h99;
    @(negedge clk);
    chk("post_ready", 32'(a_in_ready), 32'h1);
    sb.push_back('{ch: 3'd6, data: 8'h99});
    tick();
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("post_valid", 32'(a_out_valid), 32'h40);
    tick();
    tick();

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_demux_n.md
Name: stream_demux_n

Overview:
- Registered, flow-controlled 1-to-NUM_CH demultiplexer with a valid/ready handshake on every port.
- Next generation of the combinational 2x1/8x1 demux trees: adds parametrised data width and channel count, one pipeline register, per-channel backpressure and out-of-range select detection.
- Sits between a single producer and NUM_CH consumer channels in the datapath.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- NUM_CH, 8, number of output channels (2..16).
- SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_CH (elaboration error otherwise).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer beat valid.
- in_ready  output  1  block accepts beat this cycle.
- in_data  input  DATA_W  producer payload.
- in_sel  input  SEL_W  destination channel index.
- out_valid  output  NUM_CH  per-channel valid; at most one bit set.
- out_ready  input  NUM_CH  per-channel consumer ready.
- out_data  output  DATA_W  payload shared by all channels.
- clr_err  input  1  synchronous clear of err_sel and drop_count.
- err_sel  output  1  sticky flag: an out-of-range select was dropped.
- drop_count  output  16  count of dropped beats, saturating.

Behaviour:
- Reset (async, rst_n=0): hold_valid=0, hold_ch=0, out_data=0, out_valid=0, err_sel=0, drop_count=0. in_ready reads 1 once rst_n deasserts. Reset mid-transfer discards the held beat, with no output glitch beyond the reset clear.
- Internal state: one holding register {hold_valid, hold_ch[SEL_W], hold_data[DATA_W]}.
- in_ready = !hold_valid || out_ready[hold_ch]. This is a combinational path from out_ready to in_ready, with no path from in_valid.
- Accept: in_valid && in_ready at a rising edge.
- Accept with in_sel < NUM_CH: hold_valid<=1, hold_ch<=in_sel, hold_data<=in_data.
- Accept with in_sel >= NUM_CH: the beat is dropped and not loaded. hold_valid<=0 if the held beat drained this cycle, else unchanged. err_sel<=1. drop_count<=drop_count+1, saturating at 0xFFFF.
- Drain: hold_valid && out_ready[hold_ch]. If there is no simultaneous valid accept, hold_valid<=0.
- Simultaneous drain and accept: the new beat replaces the held beat in the same edge. This gives full throughput (1 beat/cycle) when the destination is ready.
- out_valid[i] = hold_valid && (hold_ch==i). out_data = hold_data. While stalled, out_valid, out_data and hold_ch remain stable.
- out_data keeps the last value after drain (not zeroed). It reads 0 only after reset.
- Latency: input accept to out_valid high is exactly 1 cycle.
- Ready on non-selected channels is ignored. Any consumer deasserting ready stalls only when it is the held destination.
- clr_err: err_sel<=0, drop_count<=0. If a drop occurs in the same cycle, the event wins: err_sel=1, drop_count=1.
- Ordering: beats leave in acceptance order. The block has no reordering or broadcast.

Test Plan:
- Reset then NUM_CH=8, DATA_W=8. Send in_sel=0..7 with in_data=0xA0+sel and all out_ready=1, one beat per cycle -> out_valid one-hot 0x01,0x02..0x80 on cycles 1..8 with matching data, and in_ready held at 1 throughout.
- Hold beat 0x55 to ch3 with out_ready[3]=0 for 5 cycles while in_valid is high -> in_ready=0, out_valid=0x08 and out_data=0x55 stable. Raising out_ready[3] drains the beat and accepts the next beat the same cycle.
- Stall ch3 while out_ready on all other channels = 1 -> the block still stalls. Toggling unrelated ready bits has no effect.
- NUM_CH=6, SEL_W=3. Send in_sel=6 and 7 -> beats dropped, out_valid stays 0, err_sel=1, drop_count=2. clr_err pulse -> both read 0. clr_err coincident with a drop -> drop_count=1.
- Force drop_count to 0xFFFF via 65535 bad beats, then one more -> the count holds at 0xFFFF.
- Assert rst_n=0 asynchronously mid-cycle with a held beat -> out_valid=0 and out_data=0 immediately. After release, in_ready=1 and no stale beat appears.
